// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier: one Booth step per clock on (WIDTH+1)-bit
// extended operands, with valid/ready handshakes on operands and product.
module booth_mult_seq #(
   parameter int WIDTH = 16,
   parameter int CNT_W = $clog2(WIDTH + 2)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 is_signed,
   input  logic [WIDTH-1:0]     mcand,
   input  logic [WIDTH-1:0]     mplier,
   input  logic                 abort,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product
);

   localparam int XW = WIDTH + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic signed [XW-1:0] acc;
   logic signed [XW-1:0] mreg;
   logic        [XW-1:0] qreg;
   logic                 q_m1;
   logic [CNT_W-1:0]     count;

   logic signed [XW-1:0] sum;
   logic signed [XW-1:0] acc_step;
   logic        [XW-1:0] q_step;
   logic                 q_m1_step;
   logic                 last_step;

   // One extra bit lets unsigned operands ride through signed Booth arithmetic exactly.
   function automatic logic signed [XW-1:0] extend(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
      logic signed [XW-1:0] r;
      r = {sgn & v[WIDTH-1], v};
      return r;
   endfunction

   function automatic logic signed [XW-1:0] booth_add(input logic signed [XW-1:0] a,
                                                      input logic signed [XW-1:0] m,
                                                      input logic [1:0] pair);
      logic signed [XW-1:0] r;
      case (pair)
         2'b01:   r = a + m;
         2'b10:   r = a - m;
         default: r = a;
      endcase
      return r;
   endfunction

   always_comb begin
      sum       = booth_add(acc, mreg, {qreg[0], q_m1});
      acc_step  = {sum[XW-1], sum[XW-1:1]};
      q_step    = {sum[0], qreg[XW-1:1]};
      q_m1_step = qreg[0];
   end

   assign last_step = (state == RUN) && (count == CNT_W'(1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Abort freezes the datapath so product keeps its previous value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc     <= '0;
         mreg    <= '0;
         qreg    <= '0;
         q_m1    <= 1'b0;
         count   <= '0;
         product <= '0;
      end else if (!abort) begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  mreg  <= extend(mcand, is_signed);
                  qreg  <= extend(mplier, is_signed);
                  acc   <= '0;
                  q_m1  <= 1'b0;
                  count <= CNT_W'(WIDTH + 1);
               end
            end
            RUN: begin
               acc   <= acc_step;
               qreg  <= q_step;
               q_m1  <= q_m1_step;
               count <= count - 1'b1;
               if (last_step) begin
                  product <= {acc_step[WIDTH-2:0], q_step};
               end
            end
            default: ;
         endcase
      end
   end

endmodule
